// File: rtl/onehot_bcd_accum_pkg.sv
// onehot_bcd_pkg: shared widths, FSM state type and one-hot check for the BCD key accumulator
package onehot_bcd_pkg;
  localparam int KEY_W = 10;
  localparam int DIGIT_W = 4;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;
  function automatic logic onehot_is_valid(input logic [KEY_W-1:0] k);
    return (k != '0) && ((k & (k - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/onehot_bcd_accum_if.sv
// onehot_bcd_accum_if: key input and BCD accumulator outputs between keypad front end and consumer
interface onehot_bcd_accum_if #(parameter int DIGITS = 4);
  import onehot_bcd_pkg::*;
  logic                         clr;
  logic [KEY_W-1:0]             key_in;
  logic                         digit_valid;
  logic [DIGIT_W-1:0]           digit_out;
  logic [DIGIT_W*DIGITS-1:0]    bcd_out;
  logic [$clog2(DIGITS+1)-1:0]  count_out;
  logic                         full;
  logic                         err;
  logic                         ovf;
  modport master (output clr, key_in, input digit_valid, digit_out, bcd_out, count_out, full, err, ovf);
  modport slave (input clr, key_in, output digit_valid, digit_out, bcd_out, count_out, full, err, ovf);
endinterface

// File: rtl/onehot_bcd_accum_digit.sv
// onehot_bcd_digit: combinational one-hot decimal key to BCD encoder with one-hot-valid flag
module onehot_bcd_digit
  import onehot_bcd_pkg::*;
(
  input  logic [KEY_W-1:0]   i_key,
  output logic [DIGIT_W-1:0] o_digit,
  output logic               o_valid
);
  always_comb begin
    o_digit = '0;
    for (int i = 0; i < KEY_W; i++) if (i_key[i]) o_digit = o_digit | DIGIT_W'(i);
  end
  assign o_valid = onehot_is_valid(i_key);
endmodule

// File: rtl/onehot_bcd_accum.sv
// onehot_bcd_accum: debounced one-hot key capture shifting BCD digits into a multi-digit accumulator.
// Define ONEHOT_BCD_ROLL_EN to discard the oldest digit instead of the new one when full.
module onehot_bcd_accum
  import onehot_bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int STABLE_CYCLES = 3
) (
  input logic clk,
  input logic rst_n,
  onehot_bcd_accum_if.slave bus
);
  localparam int BW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
`ifdef ONEHOT_BCD_ROLL_EN
  localparam bit ROLL = 1'b1;
`else
  localparam bit ROLL = 1'b0;
`endif
  state_t             r_state, w_state_nx;
  logic [7:0]         r_cnt, w_cnt_nx;
  logic [KEY_W-1:0]   r_key_q, w_key_nx;
  logic               w_accept;
  logic [BW-1:0]      r_bcd;
  logic [CW-1:0]      r_count;
  logic [DIGIT_W-1:0] r_digit, w_digit;
  logic               r_dv, r_err, r_ovf, w_valid, w_full;

  onehot_bcd_digit u_enc (.i_key(bus.key_in), .o_digit(w_digit), .o_valid(w_valid));

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx = r_cnt;
    w_key_nx = r_key_q;
    w_accept = 1'b0;
    case (r_state)
      IDLE: if (bus.key_in != '0) begin
        w_key_nx = bus.key_in;
        w_cnt_nx = 8'd1;
        w_accept = (STABLE_CYCLES == 1);
        w_state_nx = w_accept ? HELD : DEBOUNCE;
      end
      DEBOUNCE: if (bus.key_in == '0) begin
        w_state_nx = IDLE;
        w_cnt_nx = 8'd0;
      end else if (bus.key_in == r_key_q) begin
        w_cnt_nx = r_cnt + 8'd1;
        w_accept = (w_cnt_nx == 8'(STABLE_CYCLES));
        w_state_nx = w_accept ? HELD : DEBOUNCE;
      end else begin
        w_key_nx = bus.key_in;
        w_cnt_nx = 8'd1;
      end
      HELD: if (bus.key_in == '0) begin
        w_state_nx = IDLE;
        w_cnt_nx = 8'd0;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_full = (r_count == CW'(DIGITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_key_q <= '0;
      r_bcd <= '0;
      r_count <= '0;
      r_digit <= '0;
      r_dv <= 1'b0;
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt <= w_cnt_nx;
      r_key_q <= w_key_nx;
      r_dv <= 1'b0;
      r_err <= 1'b0;
      r_ovf <= 1'b0;
      // clr overrides an acceptance on the same edge
      if (bus.clr) begin
        r_bcd <= '0;
        r_count <= '0;
      end else if (w_accept && !w_valid) begin
        r_err <= 1'b1;
      end else if (w_accept) begin
        r_digit <= w_digit;
        r_dv <= 1'b1;
        r_ovf <= w_full;
        if (!w_full || ROLL) r_bcd <= (r_bcd << DIGIT_W) | BW'(w_digit);
        if (!w_full) r_count <= r_count + 1'b1;
      end
    end
  end

  assign bus.digit_valid = r_dv;
  assign bus.digit_out = r_digit;
  assign bus.bcd_out = r_bcd;
  assign bus.count_out = r_count;
  assign bus.full = w_full;
  assign bus.err = r_err;
  assign bus.ovf = r_ovf;
endmodule

// File: tb/tb_onehot_bcd_accum.sv
// tb_onehot_bcd_accum: randomized and directed stimulus checked every cycle against a sample-history model
module tb_onehot_bcd_accum;
  localparam int DIGITS = 4;
  localparam int S = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  onehot_bcd_accum_if #(.DIGITS(DIGITS)) bus ();
  onehot_bcd_accum #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [9:0] hist[$];
  bit locked;
  int digs[$];
  int m_dig;
  bit m_dv, m_err, m_ovf;
  bit cmp_en = 0;
  int dv_seen = 0, err_seen = 0, ovf_seen = 0;

  function automatic logic [63:0] m_bcd();
    logic [63:0] b = '0;
    foreach (digs[i]) b = (b << 4) | 64'(digs[i]);
    return b;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    locked = 0;
    digs.delete();
    m_dig = 0;
    m_dv = 0;
    m_err = 0;
    m_ovf = 0;
  endtask

  // a press is accepted when the last S samples are the same non-zero key and
  // nothing has been accepted since the key was last released
  task automatic model_step(input bit c, input logic [9:0] k);
    bit acc;
    int idx;
    m_dv = 0;
    m_err = 0;
    m_ovf = 0;
    hist.push_back(k);
    if (hist.size() > S) void'(hist.pop_front());
    if (k == 0) locked = 0;
    acc = !locked && k != 0 && hist.size() == S;
    foreach (hist[i]) if (hist[i] != k) acc = 0;
    if (acc) locked = 1;
    if (c) digs.delete();
    else if (acc) begin
      if ($countones(k) == 1) begin
        idx = 0;
        for (int i = 0; i < 10; i++) if (k[i]) idx = i;
        m_dig = idx;
        m_dv = 1;
        if (digs.size() == DIGITS) begin
          m_ovf = 1;
`ifdef ONEHOT_BCD_ROLL_EN
          void'(digs.pop_front());
          digs.push_back(idx);
`endif
        end else digs.push_back(idx);
      end else m_err = 1;
    end
  endtask

  always @(negedge clk) if (cmp_en) begin
    chk("digit_valid", 64'(bus.digit_valid), 64'(m_dv));
    chk("digit_out", 64'(bus.digit_out), 64'(m_dig));
    chk("bcd_out", 64'(bus.bcd_out), m_bcd());
    chk("count_out", 64'(bus.count_out), 64'(digs.size()));
    chk("full", 64'(bus.full), 64'(digs.size() == DIGITS));
    chk("err", 64'(bus.err), 64'(m_err));
    chk("ovf", 64'(bus.ovf), 64'(m_ovf));
    if (bus.digit_valid === 1'b1) dv_seen++;
    if (bus.err === 1'b1) err_seen++;
    if (bus.ovf === 1'b1) ovf_seen++;
  end

  task automatic cyc(input bit c, input logic [9:0] k);
    bus.clr = c;
    bus.key_in = k;
    @(posedge clk);
    model_step(c, k);
    @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [9:0] k, input int n);
    repeat (n) cyc(0, k);
    cyc(0, 10'd0);
  endtask

  initial begin
    logic [9:0] k;
    int r, n, a, b;
    bit c;
    bus.clr = 0;
    bus.key_in = '0;
    model_reset();
    cmp_en = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_bcd", 64'(bus.bcd_out), 64'h0);
    chk("reset_count", 64'(bus.count_out), 64'h0);
    repeat (10) cyc(0, 10'd0);
    chk("idle_pulses", 64'(dv_seen + err_seen + ovf_seen), 64'h0);
    chk("idle_bcd", 64'(bus.bcd_out), 64'h0);

    dv_seen = 0;
    press(10'b0000100000, 3);
    chk("basic_dv_once", 64'(dv_seen), 64'd1);
    chk("basic_digit", 64'(bus.digit_out), 64'd5);
    chk("basic_bcd", 64'(bus.bcd_out), 64'h0005);
    chk("basic_count", 64'(bus.count_out), 64'd1);

    cyc(1, 10'd0);
    dv_seen = 0;
    for (int i = 0; i < 6; i++) cyc(0, (i % 2 == 0) ? 10'b0000000100 : 10'd0);
    press(10'b0000000100, 3);
    chk("bounce_dv_once", 64'(dv_seen), 64'd1);
    chk("bounce_digit", 64'(bus.digit_out), 64'd2);

    cyc(1, 10'd0);
    for (int d = 1; d <= 4; d++) press(10'(1) << d, 3);
    chk("seq_bcd", 64'(bus.bcd_out), 64'h1234);
    chk("seq_full", 64'(bus.full), 64'd1);
    dv_seen = 0;
    ovf_seen = 0;
    press(10'(1) << 7, 3);
    chk("ovf_once", 64'(ovf_seen), 64'd1);
    chk("ovf_dv_once", 64'(dv_seen), 64'd1);
    chk("ovf_digit", 64'(bus.digit_out), 64'd7);
`ifdef ONEHOT_BCD_ROLL_EN
    chk("ovf_bcd", 64'(bus.bcd_out), 64'h2347);
`else
    chk("ovf_bcd", 64'(bus.bcd_out), 64'h1234);
`endif

    err_seen = 0;
    dv_seen = 0;
    press(10'b0000010010, 3);
    chk("invalid_err_once", 64'(err_seen), 64'd1);
    chk("invalid_no_dv", 64'(dv_seen), 64'd0);
    chk("invalid_count", 64'(bus.count_out), 64'd4);

    dv_seen = 0;
    cyc(0, 10'(1) << 9);
    cyc(0, 10'(1) << 9);
    cyc(1, 10'(1) << 9);
    cyc(0, 10'd0);
    chk("clr_accept_bcd", 64'(bus.bcd_out), 64'h0);
    chk("clr_accept_count", 64'(bus.count_out), 64'h0);
    chk("clr_accept_no_dv", 64'(dv_seen), 64'd0);

    press(10'(1) << 6, 3);
    cyc(0, 10'(1) << 3);
    cyc(0, 10'(1) << 3);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_bcd", 64'(bus.bcd_out), 64'h0);
    chk("midreset_count", 64'(bus.count_out), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    repeat (300) begin
      r = $urandom_range(0, 99);
      a = $urandom_range(0, 9);
      b = (a + 1 + $urandom_range(0, 8)) % 10;
      k = (r < 15) ? 10'd0 : (r < 25) ? ((10'(1) << a) | (10'(1) << b)) : (10'(1) << a);
      n = $urandom_range(1, 5);
      c = ($urandom_range(0, 29) == 0);
      for (int j = 0; j < n; j++) cyc(c && (j == n - 1), k);
    end
    cyc(0, 10'd0);
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/onehot_bcd_accum.md
Name: onehot_bcd_accum

Overview:
- Sequential successor to the team's combinational 10-line one-hot decimal-to-BCD encoder.
- Samples a 10-bit one-hot decimal key vector and debounces it over a parametrised number of cycles.
- Encodes each accepted key press to a BCD digit and shifts it into a multi-digit BCD accumulator.
- Sits between a keypad/selector front end and any consumer of a packed multi-digit BCD number, e.g. a display driver.

Parameters:
- DIGITS, 4: number of BCD digits held in the accumulator; legal range 1..8.
- STABLE_CYCLES, 3: consecutive rising edges on which an identical non-zero key_in must be sampled before it is accepted; legal range 1..255.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of the accumulator, count and flags.
- key_in  in  10  one-hot decimal key; bit i means digit i; all-zero means no key pressed.
- digit_valid  out  1  one-cycle pulse when a digit is accepted.
- digit_out  out  4  BCD value of the last accepted digit.
- bcd_out  out  4*DIGITS  packed accumulator; most recent digit in bits [3:0].
- count_out  out  $clog2(DIGITS+1)  number of digits currently held.
- full  out  1  high when count_out equals DIGITS.
- err  out  1  one-cycle pulse when a stable non-one-hot, non-zero key_in is seen.
- ovf  out  1  one-cycle pulse when a valid digit arrives while full.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the stability counter is 0.
- Reset takes effect immediately, including mid-debounce or mid-press.
- FSM states:
  - IDLE: key_in == 0. A non-zero key_in moves the FSM to DEBOUNCE, sets the counter to 1 and latches key_in into key_q.
  - DEBOUNCE: if key_in == key_q, the counter increments. If key_in != key_q and is non-zero, key_q is reloaded and the counter is set to 1. If key_in == 0, return to IDLE.
  - Acceptance: when the counter reaches STABLE_CYCLES, the press is accepted on that same edge and the FSM moves to HELD.
    - With STABLE_CYCLES = 1, acceptance happens directly from IDLE on the first sampling edge.
  - HELD: wait until key_in == 0, then return to IDLE. One acceptance per press; a held key never repeats. A change to another non-zero key while in HELD is ignored until release.
- On acceptance of a one-hot key:
  - digit_out is set to the bit index.
  - digit_valid pulses for the cycle after the accepting edge.
  - If not full: bcd_out shifts left by 4 bits, the new digit enters [3:0], and count_out increments.
  - If full: bcd_out is unchanged, count_out is unchanged, and ovf pulses; digit_valid still pulses.
- On acceptance of a non-one-hot key (two or more bits set): err pulses, and digit_out, bcd_out and count_out are unchanged.
- Latency: digit_valid rises after the STABLE_CYCLES-th consecutive edge sampling the same non-zero key_in.
- clr:
  - Clears bcd_out, count_out, full and the pulse outputs.
  - Does not alter FSM state or the stability counter.
  - Acceptance and clr on the same edge: clr wins, and no digit is stored.
- Pulse outputs are registered and are never high for two consecutive cycles from a single press.
- full is combinational from the registered count (count_out == DIGITS).

Optional Feature:
- Macro: ONEHOT_BCD_ROLL_EN.
- Defined: when full, an accepted digit still shifts in and the oldest digit (top 4 bits) is discarded. ovf still pulses and count_out stays at DIGITS.
- Undefined: the drop-new behaviour described above.

Decomposition:
- Package onehot_bcd_pkg holds:
  - KEY_W = 10 and DIGIT_W = 4;
  - the FSM state enum {IDLE, DEBOUNCE, HELD};
  - the function onehot_is_valid.
- Sub-module onehot_bcd_digit: combinational 10-to-4 encoder with a one-hot-valid flag; instantiated once in the top level.

Test Plan:
- Reset then idle: assert rst_n = 0 for 2 cycles, release, key_in = 0 for 10 cycles -> every output stays 0.
- Basic digit: key_in = 10'b0000100000 held for 3 cycles, then 0 -> digit_valid pulses exactly once, digit_out = 5, bcd_out = 16'h0005, count_out = 1.
- Bounce: key_in toggles between 10'b0000000100 and 0 every cycle for 6 cycles, then holds for 3 cycles -> exactly one digit_valid, digit_out = 2.
- Sequence and full: press keys 1, 2, 3, 4, then 7 -> bcd_out = 16'h1234 and full = 1. The press of 7 produces ovf and digit_valid pulses with bcd_out unchanged; with ONEHOT_BCD_ROLL_EN defined, bcd_out = 16'h2347 instead.
- Invalid key: key_in = 10'b0000010010 held for 3 cycles -> err pulses once; bcd_out and count_out unchanged.
- Mid-operation events:
  - Assert rst_n low during DEBOUNCE -> outputs clear immediately.
  - Assert clr on the accepting edge -> bcd_out = 0, count_out = 0, and the digit is not stored.
